// File: rtl/mem_pkg.sv
// Shared sizing and word types for the sync_memory block, its bus interface
// and the bench.
package mem_pkg;

  localparam int ADDR_WIDTH = 2;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/mem_intf.sv
// Bus between the memory and whoever drives it: request fields from the
// master, registered read result and status back from the slave.
interface mem_intf;
  import mem_pkg::*;

  addr_t addr;
  logic  wr_en;
  logic  rd_en;
  data_t wdata;
  data_t rdata;
  logic  rd_valid;
  logic  collision;

  modport master (
    output addr, wr_en, rd_en, wdata,
    input  rdata, rd_valid, collision
  );

  modport slave (
    input  addr, wr_en, rd_en, wdata,
    output rdata, rd_valid, collision
  );

endinterface

// File: rtl/mem_array.sv
// Storage array with an asynchronous clear-all and a single write port;
// the addressed word is presented combinationally for the read register.
module mem_array
  import mem_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_en,
  input  addr_t addr,
  input  data_t wdata,
  output data_t rd_word
);

  data_t mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  assign rd_word = mem[addr];

endmodule

// File: rtl/sync_memory.sv
// Single-port memory top: one write or read per cycle, read data registered
// one cycle later, with read-valid and collision status flags.
module sync_memory
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  mem_intf.slave bus
);

  data_t rd_word;
  data_t rdata_q;
  logic  rd_valid_q;
  logic  collision_q;
  logic  rd_accept;

  mem_array u_mem_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .addr    (bus.addr),
    .wdata   (bus.wdata),
    .rd_word (rd_word)
  );

  // A read that coincides with a write is dropped; the write still lands.
  assign rd_accept = bus.rd_en && !bus.wr_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      rd_valid_q  <= rd_accept;
      collision_q <= bus.rd_en && bus.wr_en;
      if (rd_accept) begin
        rdata_q <= rd_word;
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_sync_memory.sv
// Scoreboard bench for sync_memory: read results are predicted from a
// reference array when the read is issued and compared when rd_valid rises.
module tb_sync_memory;
  import mem_pkg::*;

  logic clk;
  logic reset;

  mem_intf bus ();

  sync_memory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  data_t model [DEPTH];
  data_t sb_q [$];
  data_t last_rdata;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one request at the falling edge, then check status and any read
  // result just after the following rising edge.
  task automatic apply_stimulus(input logic wr, input logic rd, input addr_t a,
                                input data_t d);
    logic  exp_valid;
    logic  exp_coll;
    data_t exp_data;
    @(negedge clk);
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.addr  = a;
    bus.wdata = d;
    exp_valid = rd && !wr;
    exp_coll  = rd && wr;
    if (exp_valid) sb_q.push_back(model[a]);
    if (wr) model[a] = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_output("rd_valid", {31'b0, bus.rd_valid}, {31'b0, exp_valid});
    check_output("collision", {31'b0, bus.collision}, {31'b0, exp_coll});
    if (bus.rd_valid) begin
      if (sb_q.size() == 0) begin
        check_output("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_data = sb_q.pop_front();
        check_output("rdata", {24'b0, bus.rdata}, {24'b0, exp_data});
        last_rdata = exp_data;
      end
    end else begin
      check_output("rdata_hold", {24'b0, bus.rdata}, {24'b0, last_rdata});
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    last_rdata = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    @(posedge clk);
    #1;
    check_output("reset_rdata", {24'b0, bus.rdata}, 32'h0);
    check_output("reset_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
    check_output("reset_collision", {31'b0, bus.collision}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] reset contents");
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 1'b1, addr_t'(i), 8'h00);

    $display("[TB] write/readback");
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 1'b0, addr_t'(i), data_t'(8'h11 * (i + 1)));
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 1'b1, addr_t'(i), 8'h00);

    $display("[TB] overwrite");
    apply_stimulus(1'b1, 1'b0, 2'd2, 8'hA5);
    apply_stimulus(1'b1, 1'b0, 2'd2, 8'h5A);
    apply_stimulus(1'b0, 1'b1, 2'd2, 8'h00);
    apply_stimulus(1'b0, 1'b1, 2'd1, 8'h00);

    $display("[TB] back-to-back read then write");
    apply_stimulus(1'b0, 1'b1, 2'd3, 8'h00);
    apply_stimulus(1'b1, 1'b0, 2'd3, 8'hFF);
    apply_stimulus(1'b0, 1'b1, 2'd3, 8'h00);
    apply_stimulus(1'b0, 1'b0, 2'd0, 8'h00);

    $display("[TB] collision");
    apply_stimulus(1'b1, 1'b1, 2'd0, 8'h77);
    apply_stimulus(1'b0, 1'b1, 2'd0, 8'h00);

    $display("[TB] reset mid-stream");
    apply_stimulus(1'b1, 1'b0, 2'd1, 8'hCC);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset_rdata", {24'b0, bus.rdata}, 32'h0);
    check_output("async_reset_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_rdata = '0;
    sb_q.delete();
    apply_stimulus(1'b0, 1'b1, 2'd1, 8'h00);

    $display("[TB] random traffic");
    for (int n = 0; n < 24; n++) begin
      logic wr;
      wr = ($urandom_range(0, 1) == 1);
      apply_stimulus(wr, !wr, addr_t'($urandom_range(0, DEPTH - 1)),
                     data_t'($urandom_range(0, 255)));
    end

    check_output("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
